// File: rtl/instr_fetch_buffer.sv
// Instruction fetch front-end: owns the fetch PC, keeps at most DEPTH words either
// in flight or buffered, and hands PC-tagged instructions to the core in order.
module instr_fetch_buffer #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;
  localparam int CW = $clog2(2 * DEPTH) + 1;

  logic [31:0]   fetch_pc;
  logic [31:0]   rsp_pc;
  logic [31:0]   fifo_data [DEPTH];
  logic [31:0]   fifo_pc   [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [OW-1:0] occ;
  logic [CW-1:0] inflight;
  logic [CW-1:0] drop;
  logic [CW-1:0] used;
  logic          req_fire;
  logic          rsp_owned;
  logic          push;
  logic          pop;

  // Live requests plus buffered words never exceed DEPTH, so a push can never overflow.
  assign used           = inflight + CW'(occ);
  assign imem_req_valid = !rst && !redirect_valid && (used < CW'(DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response belongs to someone only if a live or dropped request is outstanding.
  assign rsp_owned = imem_rsp_valid && ((drop != '0) || (inflight != '0));
  assign push      = !rst && !redirect_valid && imem_rsp_valid &&
                     (drop == '0) && (inflight != '0);

  assign instr_valid = !rst && (occ != '0);
  assign instr_data  = instr_valid ? fifo_data[rd_ptr] : '0;
  assign instr_pc    = instr_valid ? fifo_pc[rd_ptr]   : '0;
  assign pop         = instr_valid && instr_ready && !redirect_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      occ      <= '0;
      inflight <= '0;
      drop     <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc;
      rsp_pc   <= redirect_pc;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      occ      <= '0;
      inflight <= '0;
      // Everything still in flight becomes garbage; a response arriving now is consumed here.
      drop     <= drop + inflight - CW'(rsp_owned);
    end else begin
      if (req_fire) begin
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (imem_rsp_valid && (drop != '0)) begin
        drop <= drop - CW'(1);
      end
      if (push) begin
        rsp_pc <= rsp_pc + 32'd4;
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      inflight <= inflight + CW'(req_fire) - CW'(push);
      occ      <= occ + OW'(push) - OW'(pop);
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= imem_rsp_data;
      fifo_pc[wr_ptr]   <= rsp_pc;
    end
  end

endmodule
